// File: rtl/aes_top_pack.sv
// Shared AES top-level constants and types: widths, register offsets, block type.
package aes_top_pack;

  localparam int unsigned REG_SIZE          = 32;
  localparam int unsigned AES_DATA_WIDTH    = 128;
  localparam int unsigned WORD_COUNTER_SIZE = 8;
  localparam int unsigned WORDS_PER_BLOCK   = AES_DATA_WIDTH / REG_SIZE;

  // Peripheral register map (byte offsets from PERIPHERAL_ADDR)
  localparam int unsigned PERIPHERAL_ADDR   = 'h4000_0000;
  localparam int unsigned PACKER_WORD_CNT   = 'hC;
  localparam int unsigned PACKER_BLOCK_CNT  = 'h10;

  typedef logic [REG_SIZE-1:0]       aes_word_t;
  typedef logic [AES_DATA_WIDTH-1:0] aes_block_t;

endpackage

// File: rtl/aes_stat_counter.sv
// Wrapping statistics counter; clear has priority over increment.
module aes_stat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/aes_word_packer.sv
// Packs a framed 32-bit word stream into 128-bit AES blocks, zero-padding
// the tail block of each packet, with word/block statistics counters.
module aes_word_packer
  import aes_top_pack::*;
#(
  parameter int unsigned IN_WIDTH  = REG_SIZE,
  parameter int unsigned OUT_WIDTH = AES_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH = WORD_COUNTER_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  input  logic                 in_sop,
  input  logic                 in_eop,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [1:0]           out_empty,
  input  logic                 out_ready,
  input  logic                 cnt_clear,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic [CNT_WIDTH-1:0] block_cnt,
  output logic                 err_sop
);

  localparam int unsigned WPB    = OUT_WIDTH / IN_WIDTH;
  localparam int unsigned FILL_W = $clog2(WPB);
  localparam logic [FILL_W-1:0] LAST_SLOT = FILL_W'(WPB - 1);

  logic [IN_WIDTH-1:0]  slot [WPB-1];
  logic [FILL_W-1:0]    fill;
  logic [FILL_W-1:0]    eff_fill;
  logic                 first_flag;
  logic                 accept;
  logic                 handoff;
  logic                 restart;
  logic                 complete;
  logic [OUT_WIDTH-1:0] next_block;

  // A completing word may only stall behind a full, non-draining output register
  assign in_ready = ((fill < LAST_SLOT) && !in_eop) || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid && out_ready;

  // sop mid-block abandons the partial block; the word restarts at slot 0
  assign restart  = in_sop && (fill != '0);
  assign eff_fill = restart ? '0 : fill;
  assign complete = (eff_fill == LAST_SLOT) || in_eop;

  // First word lands in the MSBs; unused trailing words stay zero
  always_comb begin
    next_block = '0;
    for (int unsigned i = 0; i < WPB - 1; i++) begin
      if (i < 32'(eff_fill)) begin
        next_block[OUT_WIDTH-1-i*IN_WIDTH -: IN_WIDTH] = slot[i];
      end
    end
    next_block[OUT_WIDTH-1-32'(eff_fill)*IN_WIDTH -: IN_WIDTH] = in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < WPB - 1; i++) begin
        slot[i] <= '0;
      end
      fill       <= '0;
      first_flag <= 1'b1;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_empty  <= '0;
      err_sop    <= 1'b0;
    end else begin
      err_sop   <= accept && restart;
      out_valid <= (accept && complete) || (out_valid && !out_ready);
      if (accept) begin
        if (complete) begin
          out_data  <= next_block;
          out_sop   <= first_flag || restart;
          out_eop   <= in_eop;
          out_empty <= LAST_SLOT - eff_fill;
          fill      <= '0;
        end else begin
          slot[eff_fill] <= in_data;
          fill           <= eff_fill + FILL_W'(1);
        end
        if (in_eop) begin
          first_flag <= 1'b1;
        end else if (complete) begin
          first_flag <= 1'b0;
        end else if (restart) begin
          first_flag <= 1'b1;
        end
      end
    end
  end

  aes_stat_counter #(.WIDTH(CNT_WIDTH)) u_word_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .inc   (accept),
    .count (word_cnt)
  );

  aes_stat_counter #(.WIDTH(CNT_WIDTH)) u_block_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .inc   (handoff),
    .count (block_cnt)
  );

endmodule

// File: doc/aes_word_packer.md
Name: aes_word_packer

Overview:
- Sits between the word generator/adder output and the 128-bit AES core input.
- Accepts a packet-framed stream of 32-bit words (valid/ready, sop/eop) and packs every 4 words into one 128-bit AES block.
- Zero-pads the final partial block of a packet.
- Keeps wrapping word and block counters for the peripheral register block at PERIPHERAL_ADDR.

Parameters:
- IN_WIDTH, 32 (REG_SIZE), input word width.
- OUT_WIDTH, 128 (AES_DATA_WIDTH), output block width; OUT_WIDTH/IN_WIDTH = 4 words per block.
- CNT_WIDTH, 8 (WORD_COUNTER_SIZE), statistics counter width.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  32  input word.
- in_valid  in  1  input word valid.
- in_sop  in  1  first word of packet, qualified by in_valid.
- in_eop  in  1  last word of packet, qualified by in_valid.
- in_ready  out  1  packer can accept a word this cycle.
- out_data  out  128  packed block; first word of the block in [127:96].
- out_valid  out  1  block valid.
- out_sop  out  1  first block of packet.
- out_eop  out  1  last block of packet.
- out_empty  out  2  number of zero-padded words in the block (0..3).
- out_ready  in  1  downstream accepts the block.
- cnt_clear  in  1  synchronous clear of both counters.
- word_cnt  out  8  accepted input words, wraps modulo 256.
- block_cnt  out  8  output blocks handed off, wraps modulo 256.
- err_sop  out  1  one-cycle pulse: sop arrived mid-block.

Behaviour:
- Reset (async, immediate): out_valid=0, out_sop=0, out_eop=0, out_empty=0, out_data=0, word_cnt=0, block_cnt=0, err_sop=0, fill=0, first_flag=1. in_ready=1 once reset deasserts.
- Input accept = in_valid && in_ready. Output handoff = out_valid && out_ready.
- Accumulator: 3 word slots plus fill count 0..3. Each accepted word goes to slot[fill].
- A block completes when an accepted word has fill==3 or in_eop=1.
- On completion, the output register loads {accumulated words, current word, zero padding}:
  - out_empty = 3 - fill, using fill before the increment.
  - out_sop = first_flag.
  - out_eop = in_eop.
  - fill resets to 0.
- first_flag is set by reset and by an accepted eop word; it is cleared when a block is loaded.
- in_ready = (fill<3 && !in_eop) || !out_valid || out_ready.
  - Non-completing words are always accepted.
  - A completing word stalls only while the output register is full and not draining.
- Latency: the block is valid in the cycle after its completing word is accepted.
- Throughput: a completed block can be handed off in the same cycle the next block completes (load and drain in one cycle), giving 1 word/cycle sustained.
- Output stability: out_data/out_sop/out_eop/out_empty hold stable while out_valid && !out_ready.
- out_valid clears on handoff unless a new block loads in the same cycle.
- Accepted word with in_sop=1 while fill>0:
  - Discard the partial accumulator and pulse err_sop for one cycle.
  - The word starts a new block as slot 0 with first_flag=1.
  - It is counted in word_cnt; the discarded words are not un-counted.
- in_sop=1 and in_eop=1 on the same word: a single-word packet giving one block with out_empty=3, sop=1, eop=1.
- Counters:
  - word_cnt increments on every input accept; block_cnt increments on every output handoff.
  - Both wrap 255 -> 0.
  - cnt_clear has priority: an increment in the same cycle is lost and the counter reads 0 next cycle.
- in_sop/in_eop are ignored when in_valid=0.

Decomposition:
- Add to aes_top_pack:
  - WORDS_PER_BLOCK = AES_DATA_WIDTH/REG_SIZE.
  - PACKER_WORD_CNT = 'hC and PACKER_BLOCK_CNT = 'h10 (register offsets).
  - typedef aes_block_t = logic [AES_DATA_WIDTH-1:0].
- Natural sub-module: aes_stat_counter (CNT_WIDTH wrapping counter with inc and clear-priority), instantiated twice.

Test Plan:
- Packet of 8 words 0x1..0x8 with out_ready=1 -> 2 blocks:
  - block 1: 0x00000001_00000002_00000003_00000004, sop=1, eop=0, empty=0.
  - block 2: 0x5..0x8, sop=0, eop=1.
  - Final state: word_cnt=8, block_cnt=2.
- Packet of 6 words 0xA0..0xA5 -> block 2 = 0x000000A4_000000A5_00000000_00000000, eop=1, empty=2.
- Single word 0xDEADBEEF with sop=eop=1 -> one block 0xDEADBEEF_0..._0, sop=1, eop=1, empty=3.
- Back-pressure:
  - Setup: out_ready=0 after the first block is valid; keep streaming 4 more words.
  - Words 5-7 are accepted; in_ready drops on word 8; block 1 is held stable.
  - Raise out_ready -> block 1 drains; block 2 appears the next cycle with no data loss.
- sop after 2 words -> err_sop pulses once; the next completed block contains only the new packet's words, with sop=1.
- Counter edges:
  - 256 accepted words -> word_cnt wraps to 0.
  - cnt_clear asserted in the same cycle as an accept -> word_cnt=0 next cycle.
  - Async rst asserted mid-block -> all outputs 0 immediately; a new 4-word packet packs correctly afterwards.
